axi_rd_wr_scheduler: RTL



---
 rtl/axi_rd_wr_scheduler.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_rd_wr_scheduler.sv
// Shares one AXI3 master port between the I-cache refill, D-cache refill and D-cache write-back.
// Reads arbitrate round-robin on AR; write-back runs its own AW/W/B sequence with a line hazard check.
`timescale 1ns/1ps
module axi_rd_wr_scheduler #(
    parameter int LINE_BITS = 4
) (
    input  logic        aclk_i,
    input  logic        areset_i,

    input  logic        ireq_valid_i,
    output logic        ireq_ready_o,
    input  logic [31:0] ireq_addr_i,
    input  logic [7:0]  ireq_len_i,
    input  logic [2:0]  ireq_size_i,
    output logic        iresp_valid_o,
    output logic        iresp_last_o,
    output logic [31:0] iresp_data_o,

    input  logic        dreq_valid_i,
    output logic        dreq_ready_o,
    input  logic [31:0] dreq_addr_i,
    input  logic [7:0]  dreq_len_i,
    input  logic [2:0]  dreq_size_i,
    output logic        dresp_valid_o,
    output logic        dresp_last_o,
    output logic [31:0] dresp_data_o,

    input  logic        dw_valid_i,
    output logic        dw_ready_o,
    input  logic [31:0] dw_addr_i,
    input  logic [7:0]  dw_len_i,
    input  logic [2:0]  dw_size_i,
    input  logic        dw_data_valid_i,
    output logic        dw_data_ready_o,
    input  logic [31:0] dw_data_i,
    input  logic [3:0]  dw_strb_i,
    output logic        dw_done_o,

    output logic [3:0]  arid_o,
    output logic [31:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic        arvalid_o,
    input  logic        arready_i,

    input  logic [3:0]  rid_i,
    input  logic [31:0] rdata_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,

    output logic [3:0]  awid_o,
    output logic [31:0] awaddr_o,
    output logic [7:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic        awvalid_o,
    input  logic        awready_i,

    output logic [3:0]  wid_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wlast_o,
    output logic        wvalid_o,
    input  logic        wready_i,

    input  logic [3:0]  bid_i,
    input  logic        bvalid_i,
    output logic        bready_o
);

    localparam logic [0:0] AR_IDLE = 1'b0;
    localparam logic [0:0] AR_SEND = 1'b1;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_AW   = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;
    localparam logic [1:0] W_B    = 2'd3;

    logic [0:0]  arState_q, arState_d;
    logic        arId_q, arId_d;
    logic [31:0] arAddr_q, arAddr_d;
    logic [7:0]  arLen_q, arLen_d;
    logic [2:0]  arSize_q, arSize_d;
    logic [1:0]  outstanding_q, outstanding_d;
    logic        rrLast_q, rrLast_d;

    logic [1:0]  wState_q, wState_d;
    logic [31:0] wAddr_q, wAddr_d;
    logic [7:0]  wLen_q, wLen_d;
    logic [2:0]  wSize_q, wSize_d;
    logic [7:0]  beatCnt_q, beatCnt_d;

    logic        hazard;
    logic        instElig;
    logic        dataElig;
    logic        grantInst;
    logic        grantData;
    logic        ireqReady;
    logic        dreqReady;
    logic        wHandshake;
    logic        unused_bid;

    assign unused_bid = ^bid_i;

    // A data read must not overtake a write-back to the same line; a pending write-back request wins too.
    assign hazard = ((wState_q != W_IDLE) &&
                     (dreq_addr_i[31:LINE_BITS] == wAddr_q[31:LINE_BITS])) ||
                    ((wState_q == W_IDLE) && dw_valid_i &&
                     (dreq_addr_i[31:LINE_BITS] == dw_addr_i[31:LINE_BITS]));

    assign instElig  = ireq_valid_i && !outstanding_q[0];
    assign dataElig  = dreq_valid_i && !outstanding_q[1] && !hazard;
    assign grantInst = instElig && (!dataElig || rrLast_q);
    assign grantData = dataElig && (!instElig || !rrLast_q);

    always_comb begin
        arState_d     = arState_q;
        arId_d        = arId_q;
        arAddr_d      = arAddr_q;
        arLen_d       = arLen_q;
        arSize_d      = arSize_q;
        outstanding_d = outstanding_q;
        rrLast_d      = rrLast_q;
        ireqReady     = 1'b0;
        dreqReady     = 1'b0;

        if (rvalid_i && rlast_i && (rid_i < 4'd2)) begin
            outstanding_d[rid_i[0]] = 1'b0;
        end

        case (arState_q)
            AR_IDLE: begin
                if (grantInst) begin
                    arId_d    = 1'b0;
                    arAddr_d  = ireq_addr_i;
                    arLen_d   = ireq_len_i;
                    arSize_d  = ireq_size_i;
                    arState_d = AR_SEND;
                end else if (grantData) begin
                    arId_d    = 1'b1;
                    arAddr_d  = dreq_addr_i;
                    arLen_d   = dreq_len_i;
                    arSize_d  = dreq_size_i;
                    arState_d = AR_SEND;
                end
            end
            default: begin
                if (arready_i) begin
                    ireqReady             = !arId_q;
                    dreqReady             = arId_q;
                    outstanding_d[arId_q] = 1'b1;
                    rrLast_d              = arId_q;
                    arState_d             = AR_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            arState_q     <= AR_IDLE;
            arId_q        <= 1'b0;
            arAddr_q      <= '0;
            arLen_q       <= '0;
            arSize_q      <= '0;
            outstanding_q <= '0;
            rrLast_q      <= 1'b1;
        end else begin
            arState_q     <= arState_d;
            arId_q        <= arId_d;
            arAddr_q      <= arAddr_d;
            arLen_q       <= arLen_d;
            arSize_q      <= arSize_d;
            outstanding_q <= outstanding_d;
            rrLast_q      <= rrLast_d;
        end
    end

    assign wHandshake = (wState_q == W_DATA) && dw_data_valid_i && wready_i;

    always_comb begin
        wState_d  = wState_q;
        wAddr_d   = wAddr_q;
        wLen_d    = wLen_q;
        wSize_d   = wSize_q;
        beatCnt_d = beatCnt_q;

        case (wState_q)
            W_IDLE: begin
                if (dw_valid_i) begin
                    wAddr_d   = dw_addr_i;
                    wLen_d    = dw_len_i;
                    wSize_d   = dw_size_i;
                    beatCnt_d = 8'd0;
                    wState_d  = W_AW;
                end
            end
            W_AW: begin
                if (awready_i) begin
                    wState_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wHandshake) begin
                    beatCnt_d = beatCnt_q + 8'd1;
                    if (beatCnt_q == wLen_q) begin
                        wState_d = W_B;
                    end
                end
            end
            default: begin
                if (bvalid_i) begin
                    wState_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            wState_q  <= W_IDLE;
            wAddr_q   <= '0;
            wLen_q    <= '0;
            wSize_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            wState_q  <= wState_d;
            wAddr_q   <= wAddr_d;
            wLen_q    <= wLen_d;
            wSize_q   <= wSize_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // Handshake and response strobes are masked during reset so abandoned work never reports back.
    assign ireq_ready_o  = ireqReady && !areset_i;
    assign dreq_ready_o  = dreqReady && !areset_i;

    assign iresp_valid_o = rvalid_i && (rid_i == 4'd0) && !areset_i;
    assign iresp_last_o  = rlast_i;
    assign iresp_data_o  = rdata_i;
    assign dresp_valid_o = rvalid_i && (rid_i == 4'd1) && !areset_i;
    assign dresp_last_o  = rlast_i;
    assign dresp_data_o  = rdata_i;
    assign rready_o      = 1'b1;

    assign arvalid_o = (arState_q == AR_SEND);
    assign arid_o    = {3'b000, arId_q};
    assign araddr_o  = arAddr_q;
    assign arlen_o   = arLen_q;
    assign arsize_o  = arSize_q;

    assign awvalid_o  = (wState_q == W_AW);
    assign awid_o     = 4'd1;
    assign awaddr_o   = wAddr_q;
    assign awlen_o    = wLen_q;
    assign awsize_o   = wSize_q;
    assign dw_ready_o = (wState_q == W_AW) && awready_i && !areset_i;

    assign wid_o           = 4'd1;
    assign wvalid_o        = (wState_q == W_DATA) && dw_data_valid_i;
    assign wdata_o         = dw_data_i;
    assign wstrb_o         = dw_strb_i;
    assign wlast_o         = (wState_q == W_DATA) && (beatCnt_q == wLen_q);
    assign dw_data_ready_o = (wState_q == W_DATA) && wready_i && !areset_i;

    assign bready_o  = (wState_q == W_B);
    assign dw_done_o = (wState_q == W_B) && bvalid_i && !areset_i;

endmodule
